// File: rtl/rf_port_arbiter_if.sv
// Requester/register-file bundle for rf_port_arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface rf_port_arbiter_if #(
  parameter int unsigned wAddr = 2,
  parameter int unsigned wData = 4,
  parameter int unsigned nReq  = 3
) ();
  logic [nReq-1:0]       req;
  logic [nReq-1:0]       req_we;
  logic [nReq*wAddr-1:0] req_addr;
  logic [nReq*wData-1:0] req_wdata;
  logic [nReq-1:0]       gnt;
  logic                  rvalid;
  logic [2:0]            rid;
  logic [wData-1:0]      rdata;
  logic                  clear;
  logic                  busy;
  logic [wAddr-1:0]      rf_ra0;
  logic [wData-1:0]      rf_rd0;
  logic [wAddr-1:0]      rf_wa0;
  logic [wData-1:0]      rf_wd0;
  logic                  rf_we;

  modport master (
    output req, req_we, req_addr, req_wdata, clear, rf_rd0,
    input  gnt, rvalid, rid, rdata, busy, rf_ra0, rf_wa0, rf_wd0, rf_we
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, clear, rf_rd0,
    output gnt, rvalid, rid, rdata, busy, rf_ra0, rf_wa0, rf_wd0, rf_we
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port and one read port,
// with a clear sequencer that sweeps every register to zero.
module rf_port_arbiter #(
  parameter int unsigned wAddr = 2,
  parameter int unsigned wData = 4,
  parameter int unsigned nReq  = 3
) (
  input logic              clock,
  input logic              reset,
  rf_port_arbiter_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(nReq);
  localparam logic [wAddr-1:0] LastAddr = '1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(nReq - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [wAddr-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic             rvalid_q, rvalid_d;
  logic [2:0]       rid_q, rid_d;
  logic [wData-1:0] rdata_q, rdata_d;

  logic [wAddr-1:0] addr_arr  [nReq];
  logic [wData-1:0] wdata_arr [nReq];

  for (genvar i = 0; i < nReq; i++) begin : g_unpack
    assign addr_arr[i]  = bus_io.req_addr[i*wAddr +: wAddr];
    assign wdata_arr[i] = bus_io.req_wdata[i*wData +: wData];
  end

  // Rotating search: walk offsets from farthest to nearest so the nearest hit wins.
  logic            any_req;
  logic [IdxW-1:0] win_idx, cand_idx;

  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int unsigned off = nReq; off >= 1; off--) begin
      cand_idx = IdxW'((32'(last_q) + off) % nReq);
      if (bus_io.req[cand_idx]) begin
        any_req = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  logic [nReq-1:0]  gnt;
  logic             rf_we;
  logic [wAddr-1:0] rf_wa0, rf_ra0;
  logic [wData-1:0] rf_wd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    gnt      = '0;
    rf_we    = 1'b0;
    rf_wa0   = '0;
    rf_wd0   = '0;
    rf_ra0   = '0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (any_req) begin
          gnt[win_idx] = 1'b1;
          last_d       = win_idx;
          if (bus_io.req_we[win_idx]) begin
            rf_we  = 1'b1;
            rf_wa0 = addr_arr[win_idx];
            rf_wd0 = wdata_arr[win_idx];
          end else begin
            // Combinational register-file read is captured at the grant edge.
            rf_ra0   = addr_arr[win_idx];
            rvalid_d = 1'b1;
            rid_d    = 3'(win_idx);
            rdata_d  = bus_io.rf_rd0;
          end
        end
      end
      StClear: begin
        rf_we  = 1'b1;
        rf_wa0 = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_q   <= LastIdx;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_io.gnt    = gnt;
  assign bus_io.rvalid = rvalid_q;
  assign bus_io.rid    = rid_q;
  assign bus_io.rdata  = rdata_q;
  assign bus_io.busy   = (state_q == StClear);
  assign bus_io.rf_we  = rf_we;
  assign bus_io.rf_wa0 = rf_wa0;
  assign bus_io.rf_wd0 = rf_wd0;
  assign bus_io.rf_ra0 = rf_ra0;
endmodule
